multicycle_control_unit: RTL and testbench

// Sequential control unit for the multicycle MIPS datapath (successor to the single-cycle decoder).

---
 rtl/multicycle_control_unit_pkg.sv | 96 +++++++++
 rtl/multicycle_control_unit_if.sv | 53 +++++
 rtl/multicycle_control_unit_decode.sv | 77 +++++++
 rtl/multicycle_control_unit.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types for the multicycle MIPS control unit: opcodes, functs, ALU ops,
// FSM states, PC source and ALU operand selects, and the decoded instruction class.
package multicycle_control_unit_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B,
    OP_HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLLV = 6'h04,
    FN_SRLV = 6'h06,
    FN_JR   = 6'h08,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } mc_state_t;

  typedef enum logic [1:0] {
    PC_PC4    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } pcsrc_t;

  typedef enum logic [1:0] {
    SRC_REG   = 2'd0,
    SRC_SHAMT = 2'd1,
    SRC_SEXT  = 2'd2,
    SRC_ZEXT  = 2'd3
  } alusrc_t;

  // What the FSM needs to know about an instruction to pick its path.
  typedef enum logic [3:0] {
    CLS_R    = 4'd0,
    CLS_I    = 4'd1,
    CLS_LUI  = 4'd2,
    CLS_LW   = 4'd3,
    CLS_SW   = 4'd4,
    CLS_BEQ  = 4'd5,
    CLS_BNE  = 4'd6,
    CLS_J    = 4'd7,
    CLS_JAL  = 4'd8,
    CLS_JR   = 4'd9,
    CLS_HALT = 4'd10
  } instr_class_t;

  localparam logic [1:0] REGDST_RD = 2'd0;
  localparam logic [1:0] REGDST_RT = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle. The control unit is the master:
// it reads memory completion and the ALU zero flag, and drives all strobes.
// Handshake: iREN/dREN/dWEN are held high until the matching ihit/dhit is
// seen in the same cycle; the request drops (or the state moves) on the
// following edge.
interface multicycle_control_unit_if
  import multicycle_control_unit_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int REG_IDX_W = 5
) ();
  logic [WORD_W-1:0]    imemload;
  logic                 ihit;
  logic                 dhit;
  logic                 zero;
  logic                 iREN;
  logic                 dREN;
  logic                 dWEN;
  logic                 IRWrite;
  logic                 PCWrite;
  pcsrc_t               PCsrc;
  aluop_t               aluop;
  alusrc_t              ALUsrc;
  logic                 RegWrite;
  logic [1:0]           RegDst;
  logic                 MemtoReg;
  logic                 lui;
  logic                 link;
  logic [REG_IDX_W-1:0] rs;
  logic [REG_IDX_W-1:0] rt;
  logic [REG_IDX_W-1:0] rd;
  logic [REG_IDX_W-1:0] shamt;
  logic [WORD_W-1:0]    imm_ext;
  logic [25:0]          jaddr;
  logic                 halt;
  logic                 illegal;
  logic                 mem_err;
  mc_state_t            dbg_state;

  modport master (
    input  imemload, ihit, dhit, zero,
    output iREN, dREN, dWEN, IRWrite, PCWrite, PCsrc, aluop, ALUsrc,
           RegWrite, RegDst, MemtoReg, lui, link, rs, rt, rd, shamt,
           imm_ext, jaddr, halt, illegal, mem_err, dbg_state
  );

  modport slave (
    output imemload, ihit, dhit, zero,
    input  iREN, dREN, dWEN, IRWrite, PCWrite, PCsrc, aluop, ALUsrc,
           RegWrite, RegDst, MemtoReg, lui, link, rs, rt, rd, shamt,
           imm_ext, jaddr, halt, illegal, mem_err, dbg_state
  );
endinterface

// File: rtl/multicycle_control_unit_decode.sv
// Pure combinational instruction decode: IR -> fields, extended immediate,
// ALU op/operand select, instruction class and a legal flag.
module multicycle_control_unit_decode
  import multicycle_control_unit_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic [WORD_W-1:0]    ir,
  output logic [REG_IDX_W-1:0] rs,
  output logic [REG_IDX_W-1:0] rt,
  output logic [REG_IDX_W-1:0] rd,
  output logic [REG_IDX_W-1:0] shamt,
  output logic [WORD_W-1:0]    imm_ext,
  output logic [25:0]          jaddr,
  output aluop_t               aluop,
  output alusrc_t              alusrc,
  output instr_class_t         cls,
  output logic                 legal
);
  opcode_t opcode;
  funct_t  funct;
  logic    zext;

  assign opcode  = opcode_t'(ir[31:26]);
  assign funct   = funct_t'(ir[5:0]);
  assign rs      = ir[21 +: REG_IDX_W];
  assign rt      = ir[16 +: REG_IDX_W];
  assign rd      = ir[11 +: REG_IDX_W];
  assign shamt   = ir[6 +: REG_IDX_W];
  assign jaddr   = ir[25:0];
  // Logical immediates are zero-extended; everything else replicates bit 15.
  assign imm_ext = zext ? {{(WORD_W-16){1'b0}}, ir[15:0]}
                        : {{(WORD_W-16){ir[15]}}, ir[15:0]};

  // Opcode/funct table; anything not listed is flagged illegal.
  always_comb begin
    aluop  = ALU_ADD;
    alusrc = SRC_REG;
    cls    = CLS_R;
    legal  = 1'b1;
    zext   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLLV: begin aluop = ALU_SLL; alusrc = SRC_SHAMT; end
          FN_SRLV: begin aluop = ALU_SRL; alusrc = SRC_SHAMT; end
          FN_JR:   cls = CLS_JR;
          FN_ADD, FN_ADDU: aluop = ALU_ADD;
          FN_SUB, FN_SUBU: aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_XOR:  aluop = ALU_XOR;
          FN_NOR:  aluop = ALU_NOR;
          FN_SLT:  aluop = ALU_SLT;
          FN_SLTU: aluop = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      OP_J:     cls = CLS_J;
      OP_JAL:   cls = CLS_JAL;
      OP_BEQ:   begin cls = CLS_BEQ; aluop = ALU_SUB; end
      OP_BNE:   begin cls = CLS_BNE; aluop = ALU_SUB; end
      OP_ADDI, OP_ADDIU: begin cls = CLS_I; alusrc = SRC_SEXT; end
      OP_SLTI:  begin cls = CLS_I; aluop = ALU_SLT;  alusrc = SRC_SEXT; end
      OP_SLTIU: begin cls = CLS_I; aluop = ALU_SLTU; alusrc = SRC_SEXT; end
      OP_ANDI:  begin cls = CLS_I; aluop = ALU_AND; alusrc = SRC_ZEXT; zext = 1'b1; end
      OP_ORI:   begin cls = CLS_I; aluop = ALU_OR;  alusrc = SRC_ZEXT; zext = 1'b1; end
      OP_XORI:  begin cls = CLS_I; aluop = ALU_XOR; alusrc = SRC_ZEXT; zext = 1'b1; end
      OP_LUI:   cls = CLS_LUI;
      OP_LW:    begin cls = CLS_LW; alusrc = SRC_SEXT; end
      OP_SW:    begin cls = CLS_SW; alusrc = SRC_SEXT; end
      OP_HALT:  cls = CLS_HALT;
      default:  legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: owns the IR, the FETCH/DECODE/EXEC/MEM/WB
// sequencer, the memory-wait timeout counter and the sticky halt/error flags.
// Strobes are Moore-style from state and IR, qualified by ihit/dhit/zero.
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int REG_IDX_W  = 5,
  parameter int WAIT_LIMIT = 0
) (
  input  logic                         CLK,
  input  logic                         nRST,
  multicycle_control_unit_if.master    bus
);
  localparam int CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  mc_state_t         state_q, state_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              halt_q, halt_d;
  logic              mem_err_q, mem_err_d;

  aluop_t            dec_aluop;
  alusrc_t           dec_alusrc;
  instr_class_t      dec_cls;
  logic              dec_legal;
  logic              at_limit;

  logic    o_iren, o_dren, o_dwen, o_irwrite, o_pcwrite;
  pcsrc_t  o_pcsrc;
  aluop_t  o_aluop;
  alusrc_t o_alusrc;
  logic    o_regwrite, o_memtoreg, o_lui, o_link, o_illegal;
  logic [1:0] o_regdst;

  multicycle_control_unit_decode #(
    .WORD_W    (WORD_W),
    .REG_IDX_W (REG_IDX_W)
  ) u_decode (
    .ir      (ir_q),
    .rs      (bus.rs),
    .rt      (bus.rt),
    .rd      (bus.rd),
    .shamt   (bus.shamt),
    .imm_ext (bus.imm_ext),
    .jaddr   (bus.jaddr),
    .aluop   (dec_aluop),
    .alusrc  (dec_alusrc),
    .cls     (dec_cls),
    .legal   (dec_legal)
  );

  // The last allowed wait cycle; a hit in this cycle still wins.
  assign at_limit = (WAIT_LIMIT != 0) && (wait_cnt_q == LIMIT_M1);

  // Next-state, IR/counter/flag updates and per-state strobes.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    o_iren     = 1'b0;
    o_dren     = 1'b0;
    o_dwen     = 1'b0;
    o_irwrite  = 1'b0;
    o_pcwrite  = 1'b0;
    o_pcsrc    = PC_PC4;
    o_aluop    = ALU_SLL;
    o_alusrc   = SRC_REG;
    o_regwrite = 1'b0;
    o_regdst   = REGDST_RD;
    o_memtoreg = 1'b0;
    o_lui      = 1'b0;
    o_link     = 1'b0;
    o_illegal  = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        o_iren = 1'b1;
        if (bus.ihit) begin
          o_irwrite = 1'b1;
          o_pcwrite = 1'b1;
          ir_d      = bus.imemload;
          state_d   = ST_DECODE;
        end else if (at_limit) begin
          mem_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_DECODE: begin
        if (!dec_legal) begin
          o_illegal = 1'b1;
          state_d   = ST_FETCH;
        end else begin
          case (dec_cls)
            CLS_HALT: state_d = ST_HALT;
            CLS_J: begin
              o_pcwrite = 1'b1;
              o_pcsrc   = PC_JUMP;
              state_d   = ST_FETCH;
            end
            CLS_JAL: begin
              o_pcwrite  = 1'b1;
              o_pcsrc    = PC_JUMP;
              o_regwrite = 1'b1;
              o_regdst   = REGDST_RA;
              o_link     = 1'b1;
              state_d    = ST_FETCH;
            end
            CLS_JR: begin
              o_pcwrite = 1'b1;
              o_pcsrc   = PC_JR;
              state_d   = ST_FETCH;
            end
            default: state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        o_aluop  = dec_aluop;
        o_alusrc = dec_alusrc;
        case (dec_cls)
          CLS_BEQ: begin
            o_pcwrite = bus.zero;
            o_pcsrc   = PC_BRANCH;
            state_d   = ST_FETCH;
          end
          CLS_BNE: begin
            o_pcwrite = !bus.zero;
            o_pcsrc   = PC_BRANCH;
            state_d   = ST_FETCH;
          end
          CLS_LW, CLS_SW: state_d = ST_MEM;
          default:        state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        o_dren = (dec_cls == CLS_LW);
        o_dwen = (dec_cls == CLS_SW);
        if (bus.dhit) begin
          state_d = (dec_cls == CLS_LW) ? ST_WB : ST_FETCH;
        end else if (at_limit) begin
          mem_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_WB: begin
        o_regwrite = 1'b1;
        o_regdst   = (dec_cls == CLS_R) ? REGDST_RD : REGDST_RT;
        o_memtoreg = (dec_cls == CLS_LW);
        o_lui      = (dec_cls == CLS_LUI);
        state_d    = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
    // Each fresh wait (entering FETCH or MEM from elsewhere) starts from zero.
    if ((state_d == ST_FETCH || state_d == ST_MEM) && (state_d != state_q)) begin
      wait_cnt_d = '0;
    end
    halt_d = halt_q | (state_d == ST_HALT);
  end

  // State, IR, wait counter and sticky flags.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= ST_RST;
      ir_q       <= '0;
      wait_cnt_q <= '0;
      halt_q     <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      wait_cnt_q <= wait_cnt_d;
      halt_q     <= halt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign bus.iREN      = o_iren;
  assign bus.dREN      = o_dren;
  assign bus.dWEN      = o_dwen;
  assign bus.IRWrite   = o_irwrite;
  assign bus.PCWrite   = o_pcwrite;
  assign bus.PCsrc     = o_pcsrc;
  assign bus.aluop     = o_aluop;
  assign bus.ALUsrc    = o_alusrc;
  assign bus.RegWrite  = o_regwrite;
  assign bus.RegDst    = o_regdst;
  assign bus.MemtoReg  = o_memtoreg;
  assign bus.lui       = o_lui;
  assign bus.link      = o_link;
  assign bus.illegal   = o_illegal;
  assign bus.halt      = halt_q;
  assign bus.mem_err   = mem_err_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multicycle control unit (WAIT_LIMIT = 4).
module tb_multicycle_control_unit;
  import multicycle_control_unit_pkg::*;

  typedef struct packed {
    logic       iren;
    logic       dren;
    logic       dwen;
    logic       irwrite;
    logic       pcwrite;
    pcsrc_t     pcsrc;
    aluop_t     aluop;
    alusrc_t    alusrc;
    logic       regwrite;
    logic [1:0] regdst;
    logic       memtoreg;
    logic       lui;
    logic       link;
    logic       halt;
    logic       illegal;
    logic       mem_err;
  } strobes_t;

  localparam int SW = $bits(strobes_t);
  localparam logic [31:0] I_ADDI = 32'h20010005;
  localparam logic [31:0] I_BEQ  = 32'h1022FFFE;
  localparam logic [31:0] I_LW   = 32'h8C220004;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_ILL  = 32'h7C000000;
  localparam logic [31:0] I_HALT = 32'hFFFFFFFF;

  // Clock and reset
  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  multicycle_control_unit_if #(.WORD_W(32), .REG_IDX_W(5)) bus ();

  multicycle_control_unit #(
    .WORD_W     (32),
    .REG_IDX_W  (5),
    .WAIT_LIMIT (4)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  // Scoreboard
  logic [SW-1:0] exp_q[$];
  int       checks      = 0;
  int       errors      = 0;
  logic     exp_halt    = 1'b0;
  logic     exp_mem_err = 1'b0;
  strobes_t e;

  function automatic strobes_t observed();
    strobes_t s;
    s.iren     = bus.iREN;
    s.dren     = bus.dREN;
    s.dwen     = bus.dWEN;
    s.irwrite  = bus.IRWrite;
    s.pcwrite  = bus.PCWrite;
    s.pcsrc    = bus.PCsrc;
    s.aluop    = bus.aluop;
    s.alusrc   = bus.ALUsrc;
    s.regwrite = bus.RegWrite;
    s.regdst   = bus.RegDst;
    s.memtoreg = bus.MemtoReg;
    s.lui      = bus.lui;
    s.link     = bus.link;
    s.halt     = bus.halt;
    s.illegal  = bus.illegal;
    s.mem_err  = bus.mem_err;
    return s;
  endfunction

  function automatic strobes_t base();
    strobes_t s;
    s         = '0;
    s.halt    = exp_halt;
    s.mem_err = exp_mem_err;
    return s;
  endfunction

  function automatic strobes_t fetch_e(input logic hit);
    strobes_t s;
    s         = base();
    s.iren    = 1'b1;
    s.irwrite = hit;
    s.pcwrite = hit;
    s.pcsrc   = PC_PC4;
    return s;
  endfunction

  function automatic strobes_t exec_e(input aluop_t op, input alusrc_t src);
    strobes_t s;
    s        = base();
    s.aluop  = op;
    s.alusrc = src;
    return s;
  endfunction

  function automatic strobes_t wb_e(input logic [1:0] dst, input logic m2r, input logic lu);
    strobes_t s;
    s          = base();
    s.regwrite = 1'b1;
    s.regdst   = dst;
    s.memtoreg = m2r;
    s.lui      = lu;
    return s;
  endfunction

  // Push the expectation, let outputs settle, pop and compare.
  task automatic chk(input strobes_t exp_s, input string tag);
    logic [SW-1:0] exp_v;
    logic [SW-1:0] got_v;
    exp_q.push_back(exp_s);
    #1;
    got_v = observed();
    exp_v = exp_q.pop_front();
    checks++;
    assert (got_v === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got_v, exp_v);
    end
  endtask

  task automatic chk_val(input logic [31:0] got, input logic [31:0] exp_v, input string tag);
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp_v);
    end
  endtask

  // Driver: one cycle of inputs applied after the falling edge, then checked.
  task automatic cyc(input logic ih, input logic dh, input logic z,
                     input logic [31:0] instr, input strobes_t exp_s, input string tag);
    @(negedge CLK);
    bus.ihit     = ih;
    bus.dhit     = dh;
    bus.zero     = z;
    bus.imemload = instr;
    chk(exp_s, tag);
  endtask

  task automatic release_reset(input string tag);
    @(negedge CLK);
    nRST = 1'b1;
    chk(base(), tag);
  endtask

  initial begin
    bus.imemload = '0;
    bus.ihit     = 1'b0;
    bus.dhit     = 1'b0;
    bus.zero     = 1'b0;

    cyc(1'b0, 1'b0, 1'b0, '0, base(), "reset_hold0");
    cyc(1'b1, 1'b1, 1'b1, '0, base(), "reset_hold1");
    release_reset("rst_state");

    // ADDI with two wait cycles before ihit
    cyc(1'b0, 1'b0, 1'b0, I_ADDI, fetch_e(1'b0), "addi_fetch_w0");
    cyc(1'b0, 1'b0, 1'b0, I_ADDI, fetch_e(1'b0), "addi_fetch_w1");
    cyc(1'b1, 1'b0, 1'b0, I_ADDI, fetch_e(1'b1), "addi_fetch_hit");
    cyc(1'b0, 1'b0, 1'b0, '0, base(), "addi_decode");
    chk_val(32'(bus.rt), 32'd1, "addi_rt_from_ir");
    cyc(1'b0, 1'b0, 1'b0, '0, exec_e(ALU_ADD, SRC_SEXT), "addi_exec");
    chk_val(bus.imm_ext, 32'h00000005, "addi_imm_ext");
    cyc(1'b0, 1'b0, 1'b0, '0, wb_e(REGDST_RT, 1'b0, 1'b0), "addi_wb");
    chk_val(32'(bus.rt), 32'd1, "addi_wb_rt");

    // BEQ taken
    cyc(1'b1, 1'b0, 1'b0, I_BEQ, fetch_e(1'b1), "beq_t_fetch");
    cyc(1'b0, 1'b0, 1'b0, '0, base(), "beq_t_decode");
    e = exec_e(ALU_SUB, SRC_REG);
    e.pcwrite = 1'b1;
    e.pcsrc   = PC_BRANCH;
    cyc(1'b0, 1'b0, 1'b1, '0, e, "beq_t_exec");
    chk_val(bus.imm_ext, 32'hFFFFFFFE, "beq_imm_ext");

    // BEQ not taken
    cyc(1'b1, 1'b0, 1'b0, I_BEQ, fetch_e(1'b1), "beq_nt_fetch");
    cyc(1'b0, 1'b0, 1'b1, '0, base(), "beq_nt_decode");
    e = exec_e(ALU_SUB, SRC_REG);
    e.pcsrc = PC_BRANCH;
    cyc(1'b0, 1'b0, 1'b0, '0, e, "beq_nt_exec");

    // LW with dhit on the fourth MEM cycle (the limit cycle)
    cyc(1'b1, 1'b0, 1'b0, I_LW, fetch_e(1'b1), "lw_fetch");
    cyc(1'b0, 1'b0, 1'b0, '0, base(), "lw_decode");
    cyc(1'b0, 1'b0, 1'b0, '0, exec_e(ALU_ADD, SRC_SEXT), "lw_exec");
    e = base();
    e.dren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, (i == 3), 1'b0, '0, e, "lw_mem");
    end
    cyc(1'b0, 1'b0, 1'b0, '0, wb_e(REGDST_RT, 1'b1, 1'b0), "lw_wb");

    // JAL
    cyc(1'b1, 1'b0, 1'b0, I_JAL, fetch_e(1'b1), "jal_fetch");
    e = base();
    e.pcwrite  = 1'b1;
    e.pcsrc    = PC_JUMP;
    e.regwrite = 1'b1;
    e.regdst   = REGDST_RA;
    e.link     = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0, e, "jal_decode");
    chk_val(32'(bus.jaddr), 32'h00000010, "jal_jaddr");

    // R-type ADD $3,$1,$2
    cyc(1'b1, 1'b0, 1'b0, I_ADD, fetch_e(1'b1), "add_fetch");
    cyc(1'b0, 1'b0, 1'b0, '0, base(), "add_decode");
    cyc(1'b0, 1'b0, 1'b0, '0, exec_e(ALU_ADD, SRC_REG), "add_exec");
    cyc(1'b0, 1'b0, 1'b0, '0, wb_e(REGDST_RD, 1'b0, 1'b0), "add_wb");
    chk_val(32'(bus.rd), 32'd3, "add_rd");

    // Unknown opcode
    cyc(1'b1, 1'b0, 1'b0, I_ILL, fetch_e(1'b1), "ill_fetch");
    e = base();
    e.illegal = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0, e, "ill_decode");
    cyc(1'b0, 1'b0, 1'b0, '0, fetch_e(1'b0), "ill_back_fetch");

    // Reset asserted while a load is waiting in MEM
    cyc(1'b1, 1'b0, 1'b0, I_LW, fetch_e(1'b1), "rlw_fetch");
    cyc(1'b0, 1'b0, 1'b0, '0, base(), "rlw_decode");
    cyc(1'b0, 1'b0, 1'b0, '0, exec_e(ALU_ADD, SRC_SEXT), "rlw_exec");
    e = base();
    e.dren = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0, e, "rlw_mem");
    #2;
    nRST = 1'b0;
    chk(base(), "rst_async_mid_mem");
    cyc(1'b0, 1'b0, 1'b0, '0, base(), "rst_hold2");
    release_reset("rst_release_state");

    // Fetch timeout: four FETCH cycles without ihit, then sticky halt
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, '0, fetch_e(1'b0), "timeout_fetch");
    end
    exp_halt    = 1'b1;
    exp_mem_err = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom, base(), "timeout_halt");
    end

    // Reset clears the sticky flags
    #2;
    nRST        = 1'b0;
    exp_halt    = 1'b0;
    exp_mem_err = 1'b0;
    chk(base(), "rst_clears_sticky");
    release_reset("rst_release_state2");

    // HALT instruction
    cyc(1'b1, 1'b0, 1'b0, I_HALT, fetch_e(1'b1), "halt_fetch");
    cyc(1'b0, 1'b0, 1'b0, '0, base(), "halt_decode");
    exp_halt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom, base(), "halt_sticky");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
